// File: rtl/vga_pkg.sv
// =============================================================================
// Package     : vga_pkg
// Description : 800x600@60 timing constants and controller state type.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package vga_pkg;

  localparam int unsigned C_CNT_W       = 11;
  localparam int unsigned C_FRAME_CNT_W = 16;

  localparam int unsigned C_H_VISIBLE = 800;
  localparam int unsigned C_H_FRONT   = 40;
  localparam int unsigned C_H_SYNC    = 128;
  localparam int unsigned C_H_BACK    = 88;
  localparam int unsigned C_H_TOTAL   = C_H_VISIBLE + C_H_FRONT + C_H_SYNC + C_H_BACK;

  localparam int unsigned C_V_VISIBLE = 600;
  localparam int unsigned C_V_FRONT   = 1;
  localparam int unsigned C_V_SYNC    = 4;
  localparam int unsigned C_V_BACK    = 23;
  localparam int unsigned C_V_TOTAL   = C_V_VISIBLE + C_V_FRONT + C_V_SYNC + C_V_BACK;

  // Sync pulse windows, inclusive on both ends.
  localparam int unsigned C_H_SYNC_FIRST = C_H_VISIBLE + C_H_FRONT;
  localparam int unsigned C_H_SYNC_LAST  = C_H_SYNC_FIRST + C_H_SYNC - 1;
  localparam int unsigned C_V_SYNC_FIRST = C_V_VISIBLE + C_V_FRONT;
  localparam int unsigned C_V_SYNC_LAST  = C_V_SYNC_FIRST + C_V_SYNC - 1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } vga_state_e;

  function automatic logic in_window(input int unsigned val,
                                     input int unsigned lo,
                                     input int unsigned hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

`default_nettype wire

// File: rtl/vga_if_tim.sv
// =============================================================================
// Interface   : vga_if_tim
// Description : Raster position plus sync/blank bundle from the timing block.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface vga_if_tim;
  import vga_pkg::*;

  logic [C_CNT_W-1:0] hcount;
  logic [C_CNT_W-1:0] vcount;
  logic               hsync;
  logic               vsync;
  logic               hblnk;
  logic               vblnk;

  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

`default_nettype wire

// File: rtl/vga_tim_cnt.sv
// =============================================================================
// Module      : vga_tim_cnt
// Description : Modulo-TOTAL wrap counter shared by the H and V axes.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module vga_tim_cnt
  import vga_pkg::*;
#(
  parameter int unsigned TOTAL = C_H_TOTAL,
  parameter int unsigned WIDTH = C_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic [WIDTH-1:0] count_next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] C_LAST = WIDTH'(TOTAL - 1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             at_last;

  assign at_last = (count_q == C_LAST);

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = at_last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign count_next_o = count_d;
  assign wrap_o       = inc_i && at_last && !clr_i;

endmodule

`default_nettype wire

// File: rtl/vga_timing_ctl.sv
// =============================================================================
// Module      : vga_timing_ctl
// Description : 800x600@60 VGA timing generator with IDLE/RUN/STOPPING control.
//               Define VGA_TIM_FRAMECNT_EN to add the frame_cnt output.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module vga_timing_ctl
  import vga_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  vga_if_tim.out                   tim,
  output logic                     busy,
  output logic                     frame_start
`ifdef VGA_TIM_FRAMECNT_EN
  ,
  output logic [C_FRAME_CNT_W-1:0] frame_cnt
`endif
);

  vga_state_e         state_q, state_d;
  logic               frame_start_q, frame_start_d;
  logic               hsync_q, hsync_d;
  logic               vsync_q, vsync_d;
  logic               hblnk_q, hblnk_d;
  logic               vblnk_q, vblnk_d;

  logic               cnt_run;
  logic               cnt_clr;
  logic [C_CNT_W-1:0] h_count, h_count_nxt;
  logic [C_CNT_W-1:0] v_count, v_count_nxt;
  logic               h_wrap;
  logic               v_wrap;

  assign cnt_run = (state_q != ST_IDLE);
  assign cnt_clr = (state_q == ST_IDLE);

  vga_tim_cnt #(
    .TOTAL (C_H_TOTAL),
    .WIDTH (C_CNT_W)
  ) u_hcnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cnt_clr),
    .inc_i        (cnt_run),
    .count_o      (h_count),
    .count_next_o (h_count_nxt),
    .wrap_o       (h_wrap)
  );

  // v_wrap therefore marks the last pixel of a running frame.
  vga_tim_cnt #(
    .TOTAL (C_V_TOTAL),
    .WIDTH (C_CNT_W)
  ) u_vcnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (cnt_clr),
    .inc_i        (h_wrap),
    .count_o      (v_count),
    .count_next_o (v_count_nxt),
    .wrap_o       (v_wrap)
  );

  always_comb begin
    state_d       = state_q;
    frame_start_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d       = ST_RUN;
          frame_start_d = 1'b1;
        end
      end
      ST_RUN: begin
        frame_start_d = v_wrap;
        if (!en) begin
          state_d = ST_STOPPING;
        end
      end
      ST_STOPPING: begin
        if (en) begin
          state_d       = ST_RUN;
          frame_start_d = v_wrap;
        end else if (v_wrap) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Decode from next-cycle counts so registered sync/blank line up with hcount/vcount.
  always_comb begin
    hblnk_d = 1'b1;
    vblnk_d = 1'b1;
    hsync_d = 1'b0;
    vsync_d = 1'b0;
    if (state_d != ST_IDLE) begin
      hblnk_d = (32'(h_count_nxt) >= C_H_VISIBLE);
      vblnk_d = (32'(v_count_nxt) >= C_V_VISIBLE);
      hsync_d = in_window(32'(h_count_nxt), C_H_SYNC_FIRST, C_H_SYNC_LAST);
      vsync_d = in_window(32'(v_count_nxt), C_V_SYNC_FIRST, C_V_SYNC_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      frame_start_q <= 1'b0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      hblnk_q       <= 1'b1;
      vblnk_q       <= 1'b1;
    end else begin
      state_q       <= state_d;
      frame_start_q <= frame_start_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
    end
  end

`ifdef VGA_TIM_FRAMECNT_EN
  logic [C_FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  assign frame_cnt_d = v_wrap ? frame_cnt_q + 1'b1 : frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

  assign tim.hcount  = h_count;
  assign tim.vcount  = v_count;
  assign tim.hsync   = hsync_q;
  assign tim.vsync   = vsync_q;
  assign tim.hblnk   = hblnk_q;
  assign tim.vblnk   = vblnk_q;
  assign busy        = (state_q != ST_IDLE);
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_ctl.sv
// =============================================================================
// Module      : tb_vga_timing_ctl
// Description : Scoreboarded bench for vga_timing_ctl (frame counter checks
//               are active when VGA_TIM_FRAMECNT_EN is defined).
// Revision    : 1.0 - initial release
// =============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vga_timing_ctl;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic busy;
  logic frame_start;
`ifdef VGA_TIM_FRAMECNT_EN
  logic [15:0] frame_cnt;
`endif

  vga_if_tim tim ();

  vga_timing_ctl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .tim         (tim),
    .busy        (busy),
    .frame_start (frame_start)
`ifdef VGA_TIM_FRAMECNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #12.5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
    logic        fs;
    logic        busy;
    logic [15:0] fc;
  } obs_t;

  obs_t    sb[$];
  int      checks   = 0;
  int      errors   = 0;
  bit      finished = 0;
  longint  cyc      = 0;
  longint  last_fs_cyc = -1;
  longint  fs_period   = 0;
  int      cur_h = 0, cur_v = 0, prev_h = 0, prev_v = 0;
  int      hmax = 0, vmax = 0;

  // Reference model: 0 = idle, 1 = run, 2 = stopping.
  int      m_st = 0, m_h = 0, m_v = 0, m_fc = 0;
  logic    m_fs = 1'b0;

  task automatic summary();
    if (!finished) begin
      finished = 1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    if (errors >= 30) summary();
  endtask

  task automatic model_step(input logic rn, input logic e);
    bit last;
    if (!rn) begin
      m_st = 0; m_h = 0; m_v = 0; m_fc = 0; m_fs = 1'b0;
    end else if (m_st == 0) begin
      m_fs = e;
      if (e) m_st = 1;
    end else begin
      last = (m_h == 1055) && (m_v == 627);
      if (m_h == 1055) begin
        m_h = 0;
        m_v = (m_v == 627) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      if (last) m_fc = (m_fc + 1) % 65536;
      if (m_st == 1) begin
        m_fs = last;
        if (!e) m_st = 2;
      end else if (e) begin
        m_st = 1;
        m_fs = last;
      end else begin
        m_fs = 1'b0;
        if (last) m_st = 0;
      end
    end
  endtask

  function automatic obs_t model_exp();
    obs_t x;
    x.fs   = m_fs;
    x.busy = (m_st != 0);
    x.fc   = m_fc[15:0];
`ifndef VGA_TIM_FRAMECNT_EN
    x.fc   = '0;
`endif
    if (m_st == 0) begin
      x.h = '0; x.v = '0; x.hs = 1'b0; x.vs = 1'b0; x.hb = 1'b1; x.vb = 1'b1;
    end else begin
      x.h  = m_h[10:0];
      x.v  = m_v[10:0];
      x.hb = (m_h >= 800);
      x.hs = (m_h >= 840) && (m_h <= 967);
      x.vb = (m_v >= 600);
      x.vs = (m_v >= 601) && (m_v <= 604);
    end
    return x;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.h = tim.hcount; o.v = tim.vcount;
    o.hs = tim.hsync; o.vs = tim.vsync;
    o.hb = tim.hblnk; o.vb = tim.vblnk;
    o.fs = frame_start; o.busy = busy;
`ifdef VGA_TIM_FRAMECNT_EN
    o.fc = frame_cnt;
`else
    o.fc = '0;
`endif
    return o;
  endfunction

  task automatic edge_probe();
    if (m_st != 0 && m_v == 0) begin
      case (m_h)
        799: chk("hblnk_at_799", tim.hblnk, 0);
        800: chk("hblnk_at_800", tim.hblnk, 1);
        839: chk("hsync_at_839", tim.hsync, 0);
        840: chk("hsync_at_840", tim.hsync, 1);
        967: chk("hsync_at_967", tim.hsync, 1);
        968: chk("hsync_at_968", tim.hsync, 0);
        default: ;
      endcase
    end
    if (m_st != 0 && m_h == 0) begin
      case (m_v)
        599: chk("vblnk_at_599", tim.vblnk, 0);
        600: begin
          chk("vblnk_at_600", tim.vblnk, 1);
          chk("vsync_at_600", tim.vsync, 0);
        end
        601: chk("vsync_at_601", tim.vsync, 1);
        604: chk("vsync_at_604", tim.vsync, 1);
        605: chk("vsync_at_605", tim.vsync, 0);
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic rn, input logic e);
    obs_t exp_v;
    obs_t obs_v;
    rst_n = rn;
    en    = e;
    model_step(rn, e);
    sb.push_back(model_exp());
    @(posedge clk);
    #1;
    cyc++;
    exp_v = sb.pop_front();
    obs_v = observe();
    checks++;
    assert (obs_v === exp_v) else begin
      errors++;
      $error("FAIL cycle%0d observed=%h expected=%h", cyc, obs_v, exp_v);
    end
    if (errors >= 30) summary();
    prev_h = cur_h; prev_v = cur_v;
    cur_h = int'(tim.hcount); cur_v = int'(tim.vcount);
    if (cur_h > hmax) hmax = cur_h;
    if (cur_v > vmax) vmax = cur_v;
    if (frame_start === 1'b1) begin
      if (last_fs_cyc >= 0) fs_period = cyc - last_fs_cyc;
      last_fs_cyc = cyc;
    end
    edge_probe();
  endtask

  initial begin
    repeat (3_000_000) @(posedge clk);
    chk("watchdog_expired", 1, 0);
    summary();
  end

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;

    // Reset, with en asserted to show reset wins.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    chk("rst_busy", busy, 0);
    chk("rst_hblnk", tim.hblnk, 1);
    chk("rst_hcount", tim.hcount, 0);
    chk("rst_frame_start", frame_start, 0);
`ifdef VGA_TIM_FRAMECNT_EN
    chk("rst_frame_cnt", frame_cnt, 0);
`endif
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    chk("idle_busy", busy, 0);

    // Frame A: start latency, edge probes, drop en at line 300.
    step(1'b1, 1'b1);
    chk("start_hcount", tim.hcount, 0);
    chk("start_vcount", tim.vcount, 0);
    chk("start_frame_start", frame_start, 1);
    chk("start_busy", busy, 1);
    while (m_v != 300) step(1'b1, 1'b1);
    while (m_st != 0) step(1'b1, 1'b0);
    chk("stop_prev_hcount", prev_h, 1055);
    chk("stop_prev_vcount", prev_v, 627);
    chk("stop_busy", busy, 0);
    chk("stop_hblnk", tim.hblnk, 1);
    chk("stop_vblnk", tim.vblnk, 1);
    chk("stop_hcount", tim.hcount, 0);
    chk("stop_frame_start", frame_start, 0);
`ifdef VGA_TIM_FRAMECNT_EN
    chk("frame_cnt_after_a", frame_cnt, 1);
`endif
    step(1'b1, 1'b0);

    // Frame B: en dropped at line 300, reasserted at line 400.
    step(1'b1, 1'b1);
    while (!(m_h == 0 && m_v == 300)) step(1'b1, 1'b1);
    while (!(m_h == 0 && m_v == 400)) begin
      step(1'b1, 1'b0);
      if (m_h == 0 && m_v == 350) chk("busy_stopping", busy, 1);
    end
    while (!(m_h == 0 && m_v == 0)) step(1'b1, 1'b1);
    chk("wrap_frame_start", frame_start, 1);
    chk("wrap_busy", busy, 1);
    chk("frame_period", fs_period, 32'd663168);

    // Frame C, then stop; frame count holds in idle.
    while (m_v != 100) step(1'b1, 1'b1);
    while (m_st != 0) step(1'b1, 1'b0);
`ifdef VGA_TIM_FRAMECNT_EN
    chk("frame_cnt_three", frame_cnt, 3);
`endif
    repeat (5) step(1'b1, 1'b0);
`ifdef VGA_TIM_FRAMECNT_EN
    chk("frame_cnt_hold", frame_cnt, 3);
`endif

    // Reset in mid-frame at (500,250).
    step(1'b1, 1'b1);
    while (!(m_h == 500 && m_v == 250)) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("midrst_hcount", tim.hcount, 0);
    chk("midrst_vcount", tim.vcount, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_vblnk", tim.vblnk, 1);
    chk("midrst_hsync", tim.hsync, 0);
`ifdef VGA_TIM_FRAMECNT_EN
    chk("midrst_frame_cnt", frame_cnt, 0);
`endif
    repeat (3) step(1'b1, 1'b0);

    // Single-cycle en pulse keeps the frame going.
    step(1'b1, 1'b1);
    chk("pulse_frame_start", frame_start, 1);
    chk("pulse_hcount", tim.hcount, 0);
    step(1'b1, 1'b0);
    while (m_v != 5) step(1'b1, 1'b0);
    chk("pulse_busy", busy, 1);
    step(1'b0, 1'b0);
    chk("final_rst_busy", busy, 0);

    chk("hcount_max", hmax, 1055);
    chk("vcount_max", vmax, 627);
    summary();
  end

endmodule

`default_nettype wire
